// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Brief    : 2**ABITS x WIDTH register file, register 0 hard-wired to zero,
//            two combinational read ports, one write port, and a clear FSM
//            that sweeps registers 1..NREGS-1 to zero one per cycle.
//            Optional macro REGFILE_BYPASS_EN forwards write data to reads.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param #(
  parameter int WIDTH = 32,
  parameter int ABITS = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Wen,
  input  logic [ABITS-1:0] Wsel,
  input  logic [WIDTH-1:0] wdat,
  input  logic [ABITS-1:0] rsel1,
  input  logic [ABITS-1:0] rsel2,
  output logic [WIDTH-1:0] rdat1,
  output logic [WIDTH-1:0] rdat2,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             wr_drop
);

  localparam int NREGS = 2**ABITS;
  localparam logic [ABITS-1:0] LAST_PTR = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                         r_state;
  logic [ABITS-1:0]               r_ptr;
  logic                           r_busy;
  logic                           r_done;
  logic [NREGS-1:0][WIDTH-1:0]    r_regs;

  logic [NREGS-1:0]               w_wr_hot;
  logic [NREGS-1:0]               w_clr_hot;
  logic                           w_idle;
  logic                           w_wr_req;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_req = Wen && (Wsel != '0);

  // Register 0 never decodes as a target, so it keeps its reset value of zero.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
      if (gi == 0) begin : g_zero
        assign w_wr_hot[gi]  = 1'b0;
        assign w_clr_hot[gi] = 1'b0;
      end else begin : g_reg
        assign w_wr_hot[gi]  = w_wr_req && w_idle && (Wsel == ABITS'(gi));
        assign w_clr_hot[gi] = (r_state == S_SWEEP) && (r_ptr == ABITS'(gi));
      end
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (clr_req) begin
            r_state <= S_SWEEP;
            r_ptr   <= ABITS'(1);
            r_busy  <= 1'b1;
          end
        end
        S_SWEEP: begin
          // Pointer parks on the last register instead of wrapping.
          if (r_ptr == LAST_PTR) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_ptr <= r_ptr + ABITS'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ptr   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ptr   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_clr_hot[i]) begin
          r_regs[i] <= '0;
        end else if (w_wr_hot[i]) begin
          r_regs[i] <= wdat;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  assign w_byp1 = w_wr_req && w_idle && (rsel1 == Wsel);
  assign w_byp2 = w_wr_req && w_idle && (rsel2 == Wsel);
  assign rdat1  = w_byp1 ? wdat : r_regs[rsel1];
  assign rdat2  = w_byp2 ? wdat : r_regs[rsel2];
`else
  assign rdat1 = r_regs[rsel1];
  assign rdat2 = r_regs[rsel2];
`endif

  assign wr_drop  = w_wr_req && !w_idle;
  assign clr_busy = r_busy;
  assign clr_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_param
// Brief    : Self-checking bench for regfile_param (default and 3x8 instances)
//            against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        Wen;
  logic [4:0]  Wsel;
  logic [31:0] wdat;
  logic [4:0]  rsel1, rsel2;
  logic [31:0] rdat1, rdat2;
  logic        clr_req, clr_busy, clr_done, wr_drop;

  logic        s_wen;
  logic [2:0]  s_wsel;
  logic [7:0]  s_wdat;
  logic [2:0]  s_rsel1, s_rsel2;
  logic [7:0]  s_rdat1, s_rdat2;
  logic        s_clr_req, s_busy, s_done, s_drop;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_param #(.WIDTH(32), .ABITS(5)) u_dut (
    .CLK(clk), .RST(rst), .Wen(Wen), .Wsel(Wsel), .wdat(wdat),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  regfile_param #(.WIDTH(8), .ABITS(3)) u_small (
    .CLK(clk), .RST(rst), .Wen(s_wen), .Wsel(s_wsel), .wdat(s_wdat),
    .rsel1(s_rsel1), .rsel2(s_rsel2), .rdat1(s_rdat1), .rdat2(s_rdat2),
    .clr_req(s_clr_req), .clr_busy(s_busy), .clr_done(s_done), .wr_drop(s_drop)
  );

  task automatic test_reset();
    rst = 1'b1; Wen = 0; Wsel = 0; wdat = 0; rsel1 = 0; rsel2 = 0; clr_req = 0;
    s_wen = 0; s_wsel = 0; s_wdat = 0; s_rsel1 = 0; s_rsel2 = 0; s_clr_req = 0;
    repeat (2) @(negedge clk);
    rsel1 = 5'd5; rsel2 = 5'd31;
    #1;
    n_checks++;
    if (rdat1 !== 32'h0 || rdat2 !== 32'h0)
      $display("FAIL reset_read: rdat1=%h rdat2=%h expected 0", rdat1, rdat2);
    else n_pass++;
    n_checks++;
    if ({clr_busy, clr_done, wr_drop, s_busy, s_done, s_drop} !== 6'b0)
      $display("FAIL reset_flags: busy=%b done=%b drop=%b sbusy=%b expected 0",
               clr_busy, clr_done, wr_drop, s_busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
  endtask

  task automatic test_write_all();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      Wen = 1'b1; Wsel = 5'(k); wdat = 32'h1000_0000 + 32'(k);
      @(posedge clk);
      if (k != 0) model[k] = wdat;
    end
    @(negedge clk);
    Wen = 1'b0;
    for (int k = 0; k < 32; k++) begin
      logic [31:0] e1, e2;
      rsel1 = 5'(k); rsel2 = 5'(31 - k);
      #1;
      e1 = (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);
      e2 = (k == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - k);
      n_checks++;
      if (rdat1 !== e1 || rdat2 !== e2)
        $display("FAIL write_all[%0d]: rdat1=%h rdat2=%h expected %h %h", k, rdat1, rdat2, e1, e2);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    @(negedge clk);
    Wen = 1'b1; Wsel = 5'd5; wdat = 32'hDEAD_BEEF; rsel1 = 5'd5; rsel2 = 5'd0;
    #1;
    e = BYP ? 32'hDEAD_BEEF : model[5];
    n_checks++;
    if (rdat1 !== e) $display("FAIL bypass_same_cycle: rdat1=%h expected %h", rdat1, e);
    else n_pass++;
    @(posedge clk);
    model[5] = 32'hDEAD_BEEF;
    @(negedge clk);
    Wen = 1'b1; Wsel = 5'd0; wdat = 32'h1234_5678; rsel2 = 5'd0;
    #1;
    n_checks++;
    if (rdat1 !== 32'hDEAD_BEEF) $display("FAIL bypass_next_cycle: rdat1=%h expected deadbeef", rdat1);
    else n_pass++;
    n_checks++;
    if (rdat2 !== 32'h0 || wr_drop !== 1'b0)
      $display("FAIL write_reg0: rdat2=%h drop=%b expected 0 0", rdat2, wr_drop);
    else n_pass++;
    @(negedge clk);
    Wen = 1'b0;
  endtask

  task automatic test_random_rw();
    for (int it = 0; it < 150; it++) begin
      logic [31:0] e1, e2;
      logic        wr;
      @(negedge clk);
      Wen   = 1'($urandom_range(0, 1));
      Wsel  = 5'($urandom);
      wdat  = $urandom;
      rsel1 = 5'($urandom);
      rsel2 = ($urandom_range(0, 1) == 1) ? Wsel : 5'($urandom);
      #1;
      wr = Wen && (Wsel != 5'd0);
      e1 = (BYP && wr && rsel1 == Wsel) ? wdat : model[rsel1];
      e2 = (BYP && wr && rsel2 == Wsel) ? wdat : model[rsel2];
      n_checks++;
      if (rdat1 !== e1 || rdat2 !== e2 || wr_drop !== 1'b0)
        $display("FAIL random_rw[%0d]: rdat1=%h rdat2=%h drop=%b expected %h %h 0",
                 it, rdat1, rdat2, wr_drop, e1, e2);
      else n_pass++;
      @(posedge clk);
      if (wr) model[Wsel] = wdat;
    end
    @(negedge clk);
    Wen = 1'b0;
  endtask

  task automatic test_clear();
    int n, d;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      Wen = 1'b1; Wsel = 5'(k); wdat = $urandom | 32'h1;
      @(posedge clk);
      model[k] = wdat;
    end
    @(negedge clk);
    Wen = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0; d = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      if (clr_done === 1'b1) d++;
      n++;
      @(negedge clk);
    end
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    n_checks++;
    if (n !== 32) $display("FAIL clear_busy_len: busy cycles=%0d expected 32", n);
    else n_pass++;
    n_checks++;
    if (d !== 1) $display("FAIL clear_done_pulses: pulses=%0d expected 1", d);
    else n_pass++;
    for (int k = 0; k < 32; k++) begin
      rsel1 = 5'(k);
      #1;
      n_checks++;
      if (rdat1 !== model[k]) $display("FAIL clear_reg[%0d]: rdat1=%h expected %h", k, rdat1, model[k]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_sweep();
    int n, d;
    @(negedge clk);
    Wen = 1'b1; Wsel = 5'd7; wdat = 32'h77;
    @(posedge clk);
    model[7] = 32'h77;
    @(negedge clk);
    Wsel = 5'd9; wdat = 32'h99; clr_req = 1'b1;
    #1;
    n_checks++;
    if (wr_drop !== 1'b0) $display("FAIL write_with_clr_drop: drop=%b expected 0", wr_drop);
    else n_pass++;
    @(posedge clk);
    model[9] = 32'h99;
    @(negedge clk);
    Wen = 1'b0; clr_req = 1'b0; rsel1 = 5'd9; rsel2 = 5'd7;
    #1;
    n_checks++;
    if (rdat1 !== model[9] || rdat2 !== model[7])
      $display("FAIL write_with_clr_commit: rdat1=%h rdat2=%h expected %h %h", rdat1, rdat2, model[9], model[7]);
    else n_pass++;
    n = 0; d = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      Wen = (n == 3); Wsel = 5'd7; wdat = 32'h55; clr_req = (n == 5);
      #1;
      if (n == 3) begin
        n_checks++;
        if (wr_drop !== 1'b1) $display("FAIL mid_sweep_drop: drop=%b expected 1", wr_drop);
        else n_pass++;
      end
      if (clr_done === 1'b1) d++;
      n++;
      @(negedge clk);
    end
    Wen = 1'b0; clr_req = 1'b0;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    n_checks++;
    if (n !== 32 || d !== 1)
      $display("FAIL mid_sweep_len: busy cycles=%0d pulses=%0d expected 32 1", n, d);
    else n_pass++;
    #1;
    n_checks++;
    if (rdat1 !== model[9] || rdat2 !== model[7])
      $display("FAIL mid_sweep_regs: r9=%h r7=%h expected 0 0", rdat1, rdat2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    int n, d;
    @(negedge clk);
    Wen = 1'b1; Wsel = 5'd20; wdat = 32'h2020;
    @(posedge clk);
    model[20] = 32'h2020;
    @(negedge clk);
    Wen = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    rsel1 = 5'd20;
    #1;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    n_checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0)
      $display("FAIL reset_abort_flags: busy=%b done=%b expected 0 0", clr_busy, clr_done);
    else n_pass++;
    n_checks++;
    if (rdat1 !== model[20]) $display("FAIL reset_abort_reg: rdat1=%h expected %h", rdat1, model[20]);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    d = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (clr_done === 1'b1 || clr_busy === 1'b1) d++;
    end
    n_checks++;
    if (d !== 0) $display("FAIL reset_abort_no_done: active cycles=%0d expected 0", d);
    else n_pass++;
    Wen = 1'b1; Wsel = 5'd3; wdat = 32'hA5;
    @(posedge clk);
    model[3] = 32'hA5;
    @(negedge clk);
    Wen = 1'b0; rsel1 = 5'd3;
    #1;
    n_checks++;
    if (rdat1 !== model[3]) $display("FAIL reset_then_write: rdat1=%h expected %h", rdat1, model[3]);
    else n_pass++;
  endtask

  task automatic test_small();
    int n, d;
    @(negedge clk);
    s_wen = 1'b1; s_wsel = 3'd7; s_wdat = 8'hFF;
    @(negedge clk);
    s_wen = 1'b0; s_rsel1 = 3'd7;
    #1;
    n_checks++;
    if (s_rdat1 !== 8'hFF) $display("FAIL small_write: rdat1=%h expected ff", s_rdat1);
    else n_pass++;
    s_clr_req = 1'b1;
    @(negedge clk);
    s_clr_req = 1'b0;
    n = 0; d = 0;
    while (s_busy === 1'b1 && n < 50) begin
      if (s_done === 1'b1) d++;
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== 8 || d !== 1)
      $display("FAIL small_clear_len: busy cycles=%0d pulses=%0d expected 8 1", n, d);
    else n_pass++;
    #1;
    n_checks++;
    if (s_rdat1 !== 8'h00) $display("FAIL small_clear_reg: rdat1=%h expected 00", s_rdat1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_all();
    test_bypass();
    test_random_rw();
    test_clear();
    test_mid_sweep();
    test_reset_mid_sweep();
    test_small();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
